collision_tracker: RTL and testbench

// - Multi-obstacle collision detector with per-hit edge detection, lives and post-hit invulnerability.
// - Sits between the obstacle generator/scroller and the score/HUD logic of the runner game.
// - Compares the player against NOBST obstacle slots every clock.
// - Counts each overlap once, not once per cycle, and drives a PLAY/INVULN/OVER game state.

---
 rtl/game_pkg.sv | 6 +
 rtl/overlap_cmp.sv | 30 +++
 rtl/collision_tracker.sv | 136 +++++++++++++
 tb/tb_collision_tracker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game state and lane types for the runner collision logic
package game_pkg;
  typedef enum logic [1:0] {PLAY, INVULN, OVER} game_state_t;
  localparam int LANE_W = 2;
  typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/overlap_cmp.sv
// overlap_cmp: single obstacle slot vs player window compare, widened by one bit so differences never wrap
module overlap_cmp
  import game_pkg::*;
#(
  parameter int HWIDTH  = 12,
  parameter int VWIDTH  = 12,
  parameter int LWIDTH  = 2,
  parameter int HWINDOW = 8,
  parameter int VWINDOW = 5
) (
  input  logic              valid_i,
  input  logic              air_i,
  input  logic [HWIDTH-1:0] p_h_i,
  input  logic [HWIDTH-1:0] o_h_i,
  input  logic [VWIDTH-1:0] p_v_i,
  input  logic [VWIDTH-1:0] o_v_i,
  input  logic [LWIDTH-1:0] p_lane_i,
  input  logic [LWIDTH-1:0] o_lane_i,
  output logic              ov_o
);
  localparam logic [HWIDTH:0] HLIM = (HWIDTH + 1)'(HWINDOW);
  localparam logic [VWIDTH:0] VLIM = (VWIDTH + 1)'(VWINDOW);
  logic [HWIDTH:0] dh, adh;
  logic [VWIDTH:0] dv, adv;
  assign dh   = {o_h_i[HWIDTH-1], o_h_i} - {p_h_i[HWIDTH-1], p_h_i};
  assign dv   = {o_v_i[VWIDTH-1], o_v_i} - {p_v_i[VWIDTH-1], p_v_i};
  assign adh  = dh[HWIDTH] ? -dh : dh;
  assign adv  = dv[VWIDTH] ? -dv : dv;
  assign ov_o = valid_i && !air_i && (o_lane_i == p_lane_i) && (adh <= HLIM) && (adv <= VLIM);
endmodule

// File: rtl/collision_tracker.sv
// collision_tracker: per-slot overlap edge detection driving hits, lives and PLAY/INVULN/OVER state
module collision_tracker
  import game_pkg::*;
#(
  parameter int HWIDTH      = 12,
  parameter int VWIDTH      = 12,
  parameter int LWIDTH      = 2,
  parameter int NOBST       = 4,
  parameter int VWINDOW     = 5,
  parameter int HWINDOW     = 8,
  parameter int LIVES       = 3,
  parameter int COOLDOWN    = 60,
  parameter int COUNT_WIDTH = 32,
  localparam int IW         = NOBST > 1 ? $clog2(NOBST) : 1,
  localparam int CW         = $clog2(COOLDOWN + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                frame_tick,
  input  logic                                restart,
  input  logic signed [HWIDTH-1:0]            player_hoffset,
  input  logic signed [VWIDTH-1:0]            player_voffset,
  input  logic        [LWIDTH-1:0]            player_lane,
  input  logic                                player_air,
  input  logic        [NOBST-1:0]             obst_valid,
  input  logic        [NOBST-1:0][HWIDTH-1:0] obst_hoffset,
  input  logic        [NOBST-1:0][VWIDTH-1:0] obst_voffset,
  input  logic        [NOBST-1:0][LWIDTH-1:0] obst_lane,
  output logic                                hit_pulse,
  output logic        [IW-1:0]                hit_index,
  output logic        [COUNT_WIDTH-1:0]       hit_count,
  output logic        [3:0]                   lives,
  output logic                                invuln,
  output logic                                game_over
);
  localparam logic [CW-1:0] COOL = CW'(COOLDOWN);
  localparam logic [3:0]    LIV  = 4'(LIVES);
  game_state_t            state_q, state_d;
  logic [NOBST-1:0]       ov, ov_q, prev_q, prev_d, rise;
  logic [CW-1:0]          cool_q, cool_d;
  logic [3:0]             lives_q, lives_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d, first;
  logic                   pulse_q, pulse_d, hit;

  for (genvar i = 0; i < NOBST; i++) begin : g_cmp
    overlap_cmp #(
      .HWIDTH (HWIDTH),
      .VWIDTH (VWIDTH),
      .LWIDTH (LWIDTH),
      .HWINDOW(HWINDOW),
      .VWINDOW(VWINDOW)
    ) u_cmp (
      .valid_i (obst_valid[i]),
      .air_i   (player_air),
      .p_h_i   (player_hoffset),
      .o_h_i   (obst_hoffset[i]),
      .p_v_i   (player_voffset),
      .o_v_i   (obst_voffset[i]),
      .p_lane_i(player_lane),
      .o_lane_i(obst_lane[i]),
      .ov_o    (ov[i])
    );
  end

  assign rise = ov_q & ~prev_q;
  assign hit  = (state_q == PLAY) && (|rise);

  // lowest-index rising slot wins when several rise together
  always_comb begin
    first = '0;
    for (int i = NOBST - 1; i >= 0; i--) if (rise[i]) first = IW'(i);
  end

  // next game state, lives, cooldown and hit bookkeeping; only one hit per cycle is counted
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cool_d  = cool_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pulse_d = 1'b0;
    prev_d  = ov_q;
    unique case (state_q)
      PLAY: if (hit) begin
        pulse_d = 1'b1;
        idx_d   = first;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + COUNT_WIDTH'(1);
        lives_d = lives_q - 4'd1;
        state_d = lives_q > 4'd1 ? INVULN : OVER;
        cool_d  = lives_q > 4'd1 ? COOL : cool_q;
      end
      INVULN: if (frame_tick) begin
        cool_d  = cool_q - CW'(1);
        state_d = cool_q == CW'(1) ? PLAY : INVULN;
      end
      OVER: if (restart) begin
        state_d = PLAY;
        lives_d = LIV;
        cnt_d   = '0;
        prev_d  = '0;
      end
      default: state_d = PLAY;
    endcase
  end

  // overlap pipeline and game registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLAY;
      ov_q    <= '0;
      prev_q  <= '0;
      cool_q  <= '0;
      lives_q <= LIV;
      cnt_q   <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov;
      prev_q  <= prev_d;
      cool_q  <= cool_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
    end
  end

  assign hit_pulse = pulse_q;
  assign hit_index = idx_q;
  assign hit_count = cnt_q;
  assign lives     = lives_q;
  assign invuln    = state_q == INVULN;
  assign game_over = state_q == OVER;
endmodule

// File: tb/tb_collision_tracker.sv
// tb_collision_tracker: table-driven overlap vectors plus hand sequences for cooldown, game over, restart and reset
module tb_collision_tracker;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, restart = 1'b0, player_air = 1'b0;
  logic signed [11:0] player_hoffset = '0, player_voffset = '0;
  logic [1:0] player_lane = '0;
  logic [3:0] obst_valid = '0;
  logic [3:0][11:0] obst_hoffset = '0, obst_voffset = '0;
  logic [3:0][1:0] obst_lane = '0;
  logic hit_pulse, invuln, game_over;
  logic [1:0] hit_index;
  logic [31:0] hit_count;
  logic [3:0] lives;
  int n_run = 0, n_fail = 0, cyc = 0;

  typedef struct {
    string nm;
    int due, p, ix, c, l, iv, o;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string nm;
    int ph, pv, pl, air, val, oh, ov, ol, hit;
  } vec_t;
  vec_t vt[11];

  collision_tracker dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .player_hoffset(player_hoffset), .player_voffset(player_voffset),
    .player_lane(player_lane), .player_air(player_air),
    .obst_valid(obst_valid), .obst_hoffset(obst_hoffset),
    .obst_voffset(obst_voffset), .obst_lane(obst_lane),
    .hit_pulse(hit_pulse), .hit_index(hit_index), .hit_count(hit_count),
    .lives(lives), .invuln(invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int p, input int ix, input int c, input int l, input int iv, input int o);
    chk({nm, ".hit_pulse"}, int'(hit_pulse), p);
    chk({nm, ".hit_index"}, int'(hit_index), ix);
    chk({nm, ".hit_count"}, int'(hit_count), c);
    chk({nm, ".lives"}, int'(lives), l);
    chk({nm, ".invuln"}, int'(invuln), iv);
    chk({nm, ".game_over"}, int'(game_over), o);
  endtask

  task automatic expect2(input string nm, input int p, input int ix, input int c, input int l, input int iv, input int o);
    exp_t e;
    e.nm = nm;
    e.due = cyc + 2;
    e.p = p;
    e.ix = ix;
    e.c = c;
    e.l = l;
    e.iv = iv;
    e.o = o;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk_all(e.nm, e.p, e.ix, e.c, e.l, e.iv, e.o);
    end
  endtask

  always @(negedge clk) drain();

  task automatic put(input int s, input bit v, input int h, input int vv, input int l);
    obst_valid[s] = v;
    obst_hoffset[s] = 12'(h);
    obst_voffset[s] = 12'(vv);
    obst_lane[s] = 2'(l);
  endtask

  task automatic clr();
    obst_valid = '0;
    obst_hoffset = '0;
    obst_voffset = '0;
    obst_lane = '0;
    player_hoffset = '0;
    player_voffset = '0;
    player_lane = '0;
    player_air = 1'b0;
    frame_tick = 1'b0;
    restart = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all(nm, 0, 0, 0, 3, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{"dv5",      0,     0,     0, 0, 1, 0,     5,    0, 1};
    vt[1]  = '{"dv6",      0,     0,     0, 0, 1, 0,     6,    0, 0};
    vt[2]  = '{"dvm5",     0,     0,     0, 0, 1, 0,     -5,   0, 1};
    vt[3]  = '{"dh8",      0,     0,     0, 0, 1, 8,     0,    0, 1};
    vt[4]  = '{"dhm9",     0,     0,     0, 0, 1, -9,    0,    0, 0};
    vt[5]  = '{"lane",     0,     0,     0, 0, 1, 0,     0,    1, 0};
    vt[6]  = '{"air",      0,     0,     0, 1, 1, 0,     0,    0, 0};
    vt[7]  = '{"invalid",  0,     0,     0, 0, 0, 0,     0,    0, 0};
    vt[8]  = '{"vextreme", 0,     -2048, 0, 0, 1, 0,     2047, 0, 0};
    vt[9]  = '{"hextreme", 2047,  0,     0, 0, 1, -2048, 0,    0, 0};
    vt[10] = '{"corner",   100,   -30,   3, 0, 1, 92,    -35,  3, 1};
    clr();
    for (int r = 0; r < 11; r++) begin
      do_reset({"reset_", vt[r].nm});
      player_hoffset = 12'(vt[r].ph);
      player_voffset = 12'(vt[r].pv);
      player_lane = 2'(vt[r].pl);
      player_air = vt[r].air[0];
      put(0, vt[r].val[0], vt[r].oh, vt[r].ov, vt[r].ol);
      expect2(vt[r].nm, vt[r].hit, 0, vt[r].hit, vt[r].hit != 0 ? 2 : 3, vt[r].hit, 0);
      @(negedge clk);
      expect2({vt[r].nm, "_once"}, 0, 0, vt[r].hit, vt[r].hit != 0 ? 2 : 3, vt[r].hit, 0);
      repeat (6) @(negedge clk);
      chk({vt[r].nm, "_held.hit_count"}, int'(hit_count), vt[r].hit);
      clr();
    end

    do_reset("reset_sim");
    player_lane = 2'd2;
    put(1, 1'b1, 3, -2, 2);
    put(3, 1'b1, -4, 4, 2);
    expect2("sim", 1, 1, 1, 2, 1, 0);
    @(negedge clk);
    expect2("sim_once", 0, 1, 1, 2, 1, 0);
    settle();
    clr();

    do_reset("reset_seq");
    put(0, 1'b1, 0, 0, 0);
    expect2("h1", 1, 0, 1, 2, 1, 0);
    settle();
    repeat (59) tick();
    chk("inv_tick59", int'(invuln), 1);
    tick();
    chk("inv_tick60", int'(invuln), 0);
    settle();
    chk_all("no_rehit_after_cool", 0, 0, 1, 2, 0, 0);
    put(0, 1'b1, 0, 20, 0);
    repeat (2) @(negedge clk);
    put(0, 1'b1, 0, 0, 0);
    expect2("h2", 1, 0, 2, 1, 1, 0);
    settle();
    repeat (60) tick();
    chk("inv_after_h2_cool", int'(invuln), 0);
    put(0, 1'b1, 0, 20, 0);
    put(2, 1'b1, 1, 1, 0);
    expect2("h3_over", 1, 2, 3, 0, 0, 1);
    settle();
    put(2, 1'b1, 0, 20, 0);
    repeat (2) @(negedge clk);
    put(2, 1'b1, 1, 1, 0);
    expect2("over_frozen", 0, 2, 3, 0, 0, 1);
    settle();
    tick();
    chk_all("over_tick", 0, 2, 3, 0, 0, 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk_all("restart", 0, 2, 0, 3, 0, 0);
    @(negedge clk);
    chk_all("restart_rehit", 1, 2, 1, 2, 1, 0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk_all("restart_ignored", 0, 2, 1, 2, 1, 0);
    do_reset("reset_while_invuln");
    clr();
    settle();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
